// File: rtl/conv_ctrl_if.sv
// Result port of the convolution controller: one finished sum per valid/ready handshake.
`timescale 1ns/1ps
interface conv_ctrl_if #(
  parameter int X_AW = 5
);
  logic [17:0]     y_data;
  logic [X_AW-1:0] y_idx;
  logic            y_valid;
  logic            y_ready;

  // A result transfers on a cycle where y_valid & y_ready are both high. y_valid
  // never drops and y_data/y_idx never change until that transfer happens.
  modport master (output y_data, output y_idx, output y_valid, input y_ready);
  modport slave  (input y_data, input y_idx, input y_valid, output y_ready);
endinterface

// File: rtl/conv_ctrl.sv
// Sequencer for the 1-D convolution datapath: walks i over valid outputs and j over
// taps, drives memory reads, the multiplier/accumulator enables and the result port.
`timescale 1ns/1ps
module conv_ctrl #(
  parameter int X_AW = 5,
  parameter int F_AW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [X_AW:0]   x_len,
  input  logic [F_AW:0]   f_len,
  output logic            x_rd_en,
  output logic [X_AW-1:0] x_addr,
  output logic            f_rd_en,
  output logic [F_AW-1:0] f_addr,
  output logic            mul_en,
  output logic            clear_acc,
  output logic            en_acc,
  input  logic [17:0]     acc_data_i,
  conv_ctrl_if.master     y_if,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [X_AW:0]   n_q, n_d;
  logic [F_AW:0]   m_q, m_d;
  logic [X_AW-1:0] i_q, i_d;
  logic [F_AW-1:0] j_q, j_d;
  logic            drain_q, drain_d;
  logic            err_q, err_d;
  logic [1:0]      pipe_q, pipe_d;

  logic bad_len, last_j, last_i, live, issue;

  assign bad_len = (f_len == '0) || (x_len == '0) || ((X_AW+1)'(f_len) > x_len);
  assign last_j  = ((F_AW+1)'(j_q) == (m_q - (F_AW+1)'(1)));
  assign last_i  = (((X_AW+1)'(i_q) + (X_AW+1)'(m_q)) == n_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      drain_q <= 1'b0;
      err_q   <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      i_q     <= i_d;
      j_q     <= j_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      pipe_q  <= pipe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    i_d     = i_q;
    j_d     = j_q;
    drain_d = drain_q;
    err_d   = err_q;
    // Bit 0 marks memory data valid, bit 1 marks product valid.
    pipe_d  = {pipe_q[0], state_q == S_ISSUE};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d = x_len;
          m_d = f_len;
          i_d = '0;
          j_d = '0;
          if (bad_len) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (last_j) begin
          j_d     = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_OUT;
        else         drain_d = 1'b1;
      end
      S_OUT: begin
        if (y_if.y_ready) begin
          if (last_i) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks from a discarded run.
  assign live  = !reset;
  assign issue = live && (state_q == S_ISSUE);

  assign x_rd_en   = issue;
  assign f_rd_en   = issue;
  assign x_addr    = issue ? (i_q + X_AW'(j_q)) : '0;
  assign f_addr    = issue ? j_q : '0;
  assign clear_acc = issue && (j_q == '0);
  assign mul_en    = live && pipe_q[0];
  assign en_acc    = live && pipe_q[1];

  assign y_if.y_valid = live && (state_q == S_OUT);
  assign y_if.y_data  = y_if.y_valid ? acc_data_i : '0;
  assign y_if.y_idx   = live ? i_q : '0;

  assign busy        = live && ((state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_OUT));
  assign done        = live && (state_q == S_DONE);
  assign err         = done && err_q;
  assign dbg_state_o = live ? state_q : S_IDLE;

endmodule
